truth_table_sequencer: RTL and testbench

//  Upstream stimulus/check stage for the 3-input combinational circuit (A,B,C -> D).

---
 rtl/truth_table_sequencer_pkg.sv | 21 ++
 rtl/truth_table_sequencer_hold_timer.sv | 38 +++
 rtl/truth_table_sequencer.sv | 111 +++++++++++
 tb/tb_truth_table_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sequencer_pkg
// Description : Shared FSM state encoding and default expected truth table
//               for the truth-table sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_sequencer_pkg;

  // Sequencer states; DONE acts like IDLE but holds the sweep verdict
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Majority-of-three: D is high for vectors 3, 5, 6 and 7
  localparam logic [7:0] DEFAULT_EXP_TT = 8'hE8;

endpackage
`default_nettype wire

// File: rtl/truth_table_sequencer_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Counts 0..HOLD-1 while not cleared and flags the last cycle
//               of each hold window, then wraps to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
  parameter int HOLD = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);

  localparam int            CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Terminal count only counts while the window is actually running
  assign tc = (r_cnt == CNT_LAST) && !clear;

  // Hold-window counter: cleared outside a sweep, wraps at the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sequencer
// Description : Sweeps every input vector of a small combinational circuit,
//               holds each for HOLD cycles, samples the output at the end of
//               the window and scores it against an expected truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int                   N_IN   = 3,
  parameter int                   HOLD   = 20,
  parameter logic [2**N_IN-1:0]   EXP_TT = DEFAULT_EXP_TT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_d,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            smp_valid,
  output logic [N_IN-1:0] smp_vec,
  output logic            smp_ok,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  state_t r_state;
  logic   w_tc;
  logic   w_match;

  // Window timer runs only while a sweep is in progress
  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (r_state != ST_RUN),
    .tc    (w_tc)
  );

  assign w_match = (dut_d == EXP_TT[stim]);

  // Sweep FSM with vector counter, compare and error tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      stim       <= '0;
      busy       <= 1'b0;
      smp_valid  <= 1'b0;
      smp_vec    <= '0;
      smp_ok     <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      smp_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_RUN;
            busy       <= 1'b1;
            stim       <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
          end
        end
        ST_RUN: begin
          if (w_tc) begin
            smp_valid <= 1'b1;
            smp_vec   <= stim;
            smp_ok    <= w_match;
            if (!w_match) begin
              err_cnt <= err_cnt + ERR_ONE;
              // Only the first mismatch of a sweep records its vector
              if (err_cnt == '0) begin
                first_fail <= stim;
              end
            end
            if (stim == LAST_VEC) begin
              // Final sample folds into the verdict in the same edge
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              stim    <= '0;
              pass    <= (err_cnt == '0) && w_match;
            end else begin
              stim <= stim + VEC_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sequencer
// Description : Self-checking bench; one instance with HOLD=20 for the main
//               sweep scenarios and one with HOLD=2 for back-to-back sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;

  localparam logic [7:0] C_EXP = 8'hE8;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: HOLD = 20
  logic       start_a;
  logic [7:0] circuit_a;
  logic       dut_d_a;
  logic [2:0] stim_a;
  logic       busy_a, smp_valid_a, smp_ok_a, done_a, pass_a;
  logic [2:0] smp_vec_a, first_fail_a;
  logic [3:0] err_cnt_a;

  // Instance B: HOLD = 2
  logic       start_b;
  logic [7:0] circuit_b;
  logic       dut_d_b;
  logic [2:0] stim_b;
  logic       busy_b, smp_valid_b, smp_ok_b, done_b, pass_b;
  logic [2:0] smp_vec_b, first_fail_b;
  logic [3:0] err_cnt_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // The circuit under test is a lookup table indexed by the applied vector
  assign dut_d_a = circuit_a[stim_a];
  assign dut_d_b = circuit_b[stim_b];

  truth_table_sequencer #(.N_IN(3), .HOLD(20), .EXP_TT(8'hE8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_d(dut_d_a),
    .stim(stim_a), .busy(busy_a), .smp_valid(smp_valid_a), .smp_vec(smp_vec_a),
    .smp_ok(smp_ok_a), .done(done_a), .pass(pass_a), .err_cnt(err_cnt_a),
    .first_fail(first_fail_a)
  );

  truth_table_sequencer #(.N_IN(3), .HOLD(2), .EXP_TT(8'hE8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_d(dut_d_b),
    .stim(stim_b), .busy(busy_b), .smp_valid(smp_valid_b), .smp_vec(smp_vec_b),
    .smp_ok(smp_ok_b), .done(done_b), .pass(pass_b), .err_cnt(err_cnt_b),
    .first_fail(first_fail_b)
  );

  // Reference: number of vectors where the circuit disagrees with C_EXP
  function automatic int model_errs(input logic [7:0] tt);
    int n = 0;
    for (int i = 0; i < 8; i++) if (tt[i] != C_EXP[i]) n++;
    return n;
  endfunction

  // Reference: lowest disagreeing vector, 0 if none
  function automatic int model_first(input logic [7:0] tt);
    for (int i = 0; i < 8; i++) if (tt[i] != C_EXP[i]) return i;
    return 0;
  endfunction

  // Full HOLD=20 sweep on instance A checked cycle by cycle against the model
  task automatic do_sweep_a(input logic [7:0] tt, input bit inject_start, input string name);
    int  v;
    bit  exp_valid;
    circuit_a = tt;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    total_cnt++;
    if (busy_a !== 1'b1 || stim_a !== 3'd0 || done_a !== 1'b0 || err_cnt_a !== 4'd0)
      $display("FAIL %s accept: busy=%0b stim=%0d done=%0b err=%0d, want 1 0 0 0",
               name, busy_a, stim_a, done_a, err_cnt_a);
    else pass_cnt++;
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk); #1;
      exp_valid = (c % 20 == 0);
      total_cnt++;
      if (smp_valid_a !== exp_valid)
        $display("FAIL %s smp_valid c=%0d: got %0b want %0b", name, c, smp_valid_a, exp_valid);
      else pass_cnt++;
      if (exp_valid) begin
        v = c / 20 - 1;
        total_cnt++;
        if (smp_vec_a !== 3'(v) || smp_ok_a !== (tt[v] == C_EXP[v]))
          $display("FAIL %s sample c=%0d: vec=%0d ok=%0b want vec=%0d ok=%0b",
                   name, c, smp_vec_a, smp_ok_a, v, (tt[v] == C_EXP[v]));
        else pass_cnt++;
      end
      total_cnt++;
      if (busy_a !== (c < 160) || done_a !== (c == 160))
        $display("FAIL %s busy/done c=%0d: busy=%0b done=%0b want %0b %0b",
                 name, c, busy_a, done_a, (c < 160), (c == 160));
      else pass_cnt++;
      if (c < 160) begin
        total_cnt++;
        if (stim_a !== 3'(c / 20))
          $display("FAIL %s stim c=%0d: got %0d want %0d", name, c, stim_a, c / 20);
        else pass_cnt++;
      end
      if (inject_start && c == 50) start_a = 1'b1;
      if (inject_start && c == 51) start_a = 1'b0;
    end
    total_cnt++;
    if (err_cnt_a !== 4'(model_errs(tt)) || first_fail_a !== 3'(model_first(tt)) ||
        pass_a !== (model_errs(tt) == 0) || stim_a !== 3'd0)
      $display("FAIL %s verdict: err=%0d first=%0d pass=%0b stim=%0d want %0d %0d %0b 0",
               name, err_cnt_a, first_fail_a, pass_a, stim_a,
               model_errs(tt), model_first(tt), (model_errs(tt) == 0));
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    circuit_a = 8'hFF; circuit_b = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if ({stim_a, busy_a, smp_valid_a, smp_vec_a, smp_ok_a, done_a, pass_a, err_cnt_a, first_fail_a} !== '0 ||
        {stim_b, busy_b, smp_valid_b, smp_vec_b, smp_ok_b, done_b, pass_b, err_cnt_b, first_fail_b} !== '0)
      $display("FAIL reset_outputs: A busy=%0b stim=%0d B busy=%0b stim=%0d want all zero",
               busy_a, stim_a, busy_b, stim_b);
    else pass_cnt++;
    start_a = 1'b0; start_b = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || done_a !== 1'b0)
      $display("FAIL reset_idle: busyA=%0b busyB=%0b doneA=%0b want 0 0 0", busy_a, busy_b, done_a);
    else pass_cnt++;
  endtask

  task automatic test_majority();
    do_sweep_a(8'hE8, 1'b0, "majority");
  endtask

  task automatic test_stuck_zero();
    do_sweep_a(8'h00, 1'b0, "stuck0");
    total_cnt++;
    if (err_cnt_a !== 4'd4 || first_fail_a !== 3'd3 || pass_a !== 1'b0 || done_a !== 1'b1)
      $display("FAIL stuck0_const: err=%0d first=%0d pass=%0b done=%0b want 4 3 0 1",
               err_cnt_a, first_fail_a, pass_a, done_a);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    do_sweep_a(8'($urandom), 1'b1, "start_ignored");
  endtask

  task automatic test_reset_mid_sweep();
    circuit_a = 8'hE8;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (70) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (stim_a !== 3'd0 || busy_a !== 1'b0 || err_cnt_a !== 4'd0)
      $display("FAIL async_reset: stim=%0d busy=%0b err=%0d want 0 0 0", stim_a, busy_a, err_cnt_a);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (busy_a !== 1'b0 || smp_valid_a !== 1'b0)
      $display("FAIL reset_held: busy=%0b smp_valid=%0b want 0 0", busy_a, smp_valid_a);
    else pass_cnt++;
    rst_n = 1'b1;
    do_sweep_a(8'($urandom), 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) do_sweep_a(8'($urandom), 1'b0, "random");
  endtask

  // HOLD=2 with start held high: DONE lasts one cycle, next sweep starts clean
  task automatic test_back_to_back();
    logic [7:0] tt;
    int         v;
    tt = 8'($urandom) ^ 8'h01;
    if (tt == C_EXP) tt = ~C_EXP;
    circuit_b = tt;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      if (c <= 16) begin
        total_cnt++;
        if (smp_valid_b !== (c % 2 == 0))
          $display("FAIL b2b smp_valid c=%0d: got %0b want %0b", c, smp_valid_b, (c % 2 == 0));
        else pass_cnt++;
        if (c % 2 == 0) begin
          v = c / 2 - 1;
          total_cnt++;
          if (smp_vec_b !== 3'(v) || smp_ok_b !== (tt[v] == C_EXP[v]))
            $display("FAIL b2b sample c=%0d: vec=%0d ok=%0b want %0d %0b",
                     c, smp_vec_b, smp_ok_b, v, (tt[v] == C_EXP[v]));
          else pass_cnt++;
        end
      end
      if (c == 16) begin
        total_cnt++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || err_cnt_b !== 4'(model_errs(tt)) ||
            first_fail_b !== 3'(model_first(tt)) || pass_b !== 1'b0)
          $display("FAIL b2b first_done: done=%0b busy=%0b err=%0d first=%0d pass=%0b want 1 0 %0d %0d 0",
                   done_b, busy_b, err_cnt_b, first_fail_b, pass_b, model_errs(tt), model_first(tt));
        else pass_cnt++;
      end
      if (c == 17) begin
        total_cnt++;
        if (done_b !== 1'b0 || busy_b !== 1'b1 || err_cnt_b !== 4'd0 || stim_b !== 3'd0 || smp_valid_b !== 1'b0)
          $display("FAIL b2b restart: done=%0b busy=%0b err=%0d stim=%0d valid=%0b want 0 1 0 0 0",
                   done_b, busy_b, err_cnt_b, stim_b, smp_valid_b);
        else pass_cnt++;
        start_b = 1'b0;
      end
      if (c > 17) begin
        total_cnt++;
        if (busy_b !== (c < 33) || done_b !== (c == 33) || smp_valid_b !== ((c - 17) % 2 == 0))
          $display("FAIL b2b second c=%0d: busy=%0b done=%0b valid=%0b", c, busy_b, done_b, smp_valid_b);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (err_cnt_b !== 4'(model_errs(tt)) || first_fail_b !== 3'(model_first(tt)))
      $display("FAIL b2b second_verdict: err=%0d first=%0d want %0d %0d",
               err_cnt_b, first_fail_b, model_errs(tt), model_first(tt));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_majority();
    test_stuck_zero();
    test_start_ignored();
    test_reset_mid_sweep();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
